// File: rtl/flag_ctrl_if.sv
// Bundle of flag controller control/status signals.
// The master side is the sequencer/ALU; the slave side is flag_ctrl.
interface flag_ctrl_if;
  logic       alu_we;
  logic [3:0] alu_flags;
  logic [3:0] alu_mask;
  logic       ld_we;
  logic [3:0] ld_flags;
  logic       push;
  logic       pop;
  logic       cond_valid;
  logic [3:0] cond;
  logic [3:0] flags;
  logic       take_valid;
  logic       take;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_err;

  modport master (
    output alu_we, alu_flags, alu_mask, ld_we, ld_flags, push, pop, cond_valid, cond,
    input  flags, take_valid, take, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  alu_we, alu_flags, alu_mask, ld_we, ld_flags, push, pop, cond_valid, cond,
    output flags, take_valid, take, stk_full, stk_empty, stk_err
  );
endinterface

// File: rtl/flag_ctrl.sv
// CPU status flag owner {V,C,N,Z}: arbitrates flag writers, keeps a LIFO
// shadow stack for interrupt entry/return and evaluates branch conditions.
module flag_ctrl #(
  parameter int         STACK_DEPTH = 4,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input logic         clk,
  input logic         clear,
  flag_ctrl_if.slave  bus
);

  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int PW = $clog2(STACK_DEPTH) + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(STACK_DEPTH);

  typedef enum logic [3:0] {
    CC_AL = 4'd0,  CC_EQ = 4'd1,  CC_NE = 4'd2,  CC_CS = 4'd3,
    CC_CC = 4'd4,  CC_MI = 4'd5,  CC_PL = 4'd6,  CC_VS = 4'd7,
    CC_VC = 4'd8,  CC_GE = 4'd9,  CC_LT = 4'd10, CC_GT = 4'd11,
    CC_LE = 4'd12, CC_HI = 4'd13, CC_LS = 4'd14, CC_NV = 4'd15
  } cond_e;

  logic [3:0]    stack [STACK_DEPTH];
  logic [PW-1:0] count;
  logic [3:0]    flags_q, flags_nxt;
  logic          take_q, take_valid_q, stk_err_q;
  logic          full, empty;
  logic          push_ok, pop_ok, stk_illegal;
  logic [IW-1:0] top_idx;

  // Condition code evaluation on a given flag snapshot.
  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic v, cy, n, z;
    {v, cy, n, z} = f;
    case (cond_e'(c))
      CC_AL:   return 1'b1;
      CC_EQ:   return z;
      CC_NE:   return !z;
      CC_CS:   return cy;
      CC_CC:   return !cy;
      CC_MI:   return n;
      CC_PL:   return !n;
      CC_VS:   return v;
      CC_VC:   return !v;
      CC_GE:   return n == v;
      CC_LT:   return n != v;
      CC_GT:   return !z && (n == v);
      CC_LE:   return z || (n != v);
      CC_HI:   return cy && !z;
      CC_LS:   return !cy || z;
      default: return 1'b0;
    endcase
  endfunction

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign top_idx = IW'(count - PW'(1));

  // Stack legality and single-winner flag write selection.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    push_ok     = bus.push && !bus.pop && !full;
    pop_ok      = bus.pop && !bus.push && !empty;
    stk_illegal = (bus.push && bus.pop) || (bus.push && full) || (bus.pop && empty);
    flags_nxt   = flags_q;
    if (pop_ok)
      flags_nxt = stack[top_idx];
    else if (bus.ld_we)
      flags_nxt = bus.ld_flags;
    else if (bus.alu_we)
      flags_nxt = (flags_q & ~bus.alu_mask) | (bus.alu_flags & bus.alu_mask);
  end

  // Flag, stack pointer, error and condition result registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
    if (clear) begin
      flags_q      <= RESET_FLAGS;
      count        <= '0;
      stk_err_q    <= 1'b0;
      take_q       <= 1'b0;
      take_valid_q <= 1'b0;
    end else begin
      flags_q <= flags_nxt;
      if (push_ok)
        count <= count + PW'(1);
      else if (pop_ok)
        count <= count - PW'(1);
      if (stk_illegal)
        stk_err_q <= 1'b1;
      take_valid_q <= bus.cond_valid;
      if (bus.cond_valid)
        take_q <= eval_cond(bus.cond, flags_q);
    end
  end

  // Shadow stack storage: saves the pre-update flags on a legal push.
  always_ff @(posedge clk) begin
    // NOTE: the stack array has no reset; entries are only read below count, which clear zeroes.
    if (!clear && push_ok)
      stack[IW'(count)] <= flags_q;
  end

  assign bus.flags      = flags_q;
  assign bus.take       = take_q;
  assign bus.take_valid = take_valid_q;
  assign bus.stk_full   = full;
  assign bus.stk_empty  = empty;
  assign bus.stk_err    = stk_err_q;

endmodule
